// File: rtl/sync_hs_pkg.sv
// Shared types and limits for the toggle-handshake CDC receiver.
package sync_hs_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } hs_rx_state_t;

    localparam int HS_MIN_STAGES = 2;

endpackage

// File: rtl/hs_sync_chain.sv
// Multi-flop level synchronizer for a single asynchronous bit.
module hs_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    // Keep the chain as discrete flops so placement stays tight.
    (* SHREG_EXTRACT = "NO" *)
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_hs_rx.sv
// Toggle-request bundled-data CDC receiver with valid/ready output.
// Define SYNC_HS_RX_TIMEOUT_EN to discard words not taken within TIMEOUT cycles.
module sync_hs_rx
    import sync_hs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_tgl,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             timeout
);

    if (STAGES < HS_MIN_STAGES) begin : g_bad_stages
        $error("sync_hs_rx: STAGES must be at least HS_MIN_STAGES");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sync_hs_rx: TIMEOUT must be positive");
    end

    logic             req_s;
    hs_rx_state_t     state_q;
    logic             req_seen_q;
    logic             valid_q;
    logic             ack_q;
    logic             timeout_q;
    logic [WIDTH-1:0] dout_q;
    logic             pending;
    logic             accept;
    logic             expire;

    hs_sync_chain #(
        .STAGES (STAGES)
    ) u_req_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (req_tgl),
        .q_o    (req_s)
    );

    assign pending = (req_s != req_seen_q);
    assign accept  = valid_q & ready;

`ifdef SYNC_HS_RX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d  = cnt_q + 1'b1;
    assign expire = (state_q == VALID) && !ready && (cnt_d == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!ready) begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // data_in has been stable since before req_s moved.
                    if (pending) begin
                        dout_q     <= data_in;
                        req_seen_q <= req_s;
                        valid_q    <= 1'b1;
                        state_q    <= VALID;
                    end
                end
                VALID: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end else if (expire) begin
                        valid_q   <= 1'b0;
                        ack_q     <= ~ack_q;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ack_tgl = ack_q;
    assign dout    = dout_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sync_hs_rx.sv
// Directed and slow-sender random checks for sync_hs_rx.
module tb_sync_hs_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_tgl = 1'b0;
    logic [31:0] data_in = '0;
    logic        ready = 1'b0;
    logic        ack_tgl;
    logic [31:0] dout;
    logic        valid;
    logic        timeout;

    logic        sclk = 1'b0;
    logic        ack_s1 = 1'b0;
    logic        ack_s2 = 1'b0;
    logic [31:0] exp_q[$];
    bit          snd_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    sync_hs_rx #(
        .WIDTH   (32),
        .STAGES  (2),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_tgl (req_tgl),
        .data_in (data_in),
        .ack_tgl (ack_tgl),
        .dout    (dout),
        .valid   (valid),
        .ready   (ready),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Sender clock: 37 ns period, unrelated phase.
    initial begin
        #2;
        forever begin
            #18 sclk = 1'b1;
            #19 sclk = 1'b0;
        end
    end

    always @(posedge sclk) begin
        ack_s1 <= ack_tgl;
        ack_s2 <= ack_s1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        int w;
        w = 0;
        while (ack_s2 != req_tgl && w < 100) begin
            @(posedge sclk);
            w++;
        end
        if (ack_s2 != req_tgl) chk("snd_ack_wait", {31'd0, ack_s2}, {31'd0, req_tgl});
    endtask

    task automatic sender(input int n);
        for (int i = 0; i < n; i++) begin
            wait_ack();
            if (ack_s2 != req_tgl) break;
            @(posedge sclk);
            data_in = $urandom;
            exp_q.push_back(data_in);
            req_tgl = ~req_tgl;
        end
        wait_ack();
        snd_done = 1'b1;
    endtask

    initial begin
        int cyc;
        int got_n;

        // Reset and idle
        repeat (3) tick();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ack", {31'd0, ack_tgl}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", {31'd0, valid}, 32'd0);
            chk("idle_ack", {31'd0, ack_tgl}, 32'd0);
            chk("idle_timeout", {31'd0, timeout}, 32'd0);
        end

        // Single transfer, ready high
        req_tgl = 1'b1;
        data_in = 32'hDEADBEEF;
        ready   = 1'b1;
        tick();
        tick();
        chk("lat_valid_early", {31'd0, valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, valid}, 32'd1);
        chk("lat_dout", dout, 32'hDEADBEEF);
        chk("lat_ack_pre", {31'd0, ack_tgl}, 32'd0);
        tick();
        chk("acc_valid", {31'd0, valid}, 32'd0);
        chk("acc_ack", {31'd0, ack_tgl}, 32'd1);
        chk("acc_dout_kept", dout, 32'hDEADBEEF);

        // Back-pressure hold
        req_tgl = 1'b0;
        data_in = 32'h12345678;
        ready   = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 50; i++) begin
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_dout", dout, 32'h12345678);
            chk("hold_ack", {31'd0, ack_tgl}, 32'd1);
            tick();
        end
        chk("hold_valid_end", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("pulse_valid", {31'd0, valid}, 32'd0);
        chk("pulse_ack", {31'd0, ack_tgl}, 32'd0);
        chk("pulse_dout", dout, 32'h12345678);
        repeat (3) tick();
        chk("pulse_ack_once", {31'd0, ack_tgl}, 32'd0);
        chk("pulse_no_recap", {31'd0, valid}, 32'd0);

        // Slow unrelated sender, 1000 words, random ready
        cyc   = 0;
        got_n = 0;
        fork
            sender(1000);
            begin
                while (!(snd_done && exp_q.size() == 0) && cyc < 60000) begin
                    if (valid && ready) begin
                        if (exp_q.size() == 0) chk("rx_extra", 32'd1, 32'd0);
                        else chk("rx_word", dout, exp_q.pop_front());
                        got_n++;
                    end
                    tick();
                    cyc++;
                    ready = 1'($urandom_range(0, 1));
                end
            end
        join
        chk("rx_budget", {31'd0, (cyc < 60000)}, 32'd1);
        chk("rx_count", got_n, 32'd1000);
        ready = 1'b0;
        repeat (4) tick();

        // Reset while valid=1 and ack=1
        req_tgl = ~req_tgl;
        data_in = 32'h0F0F0F0F;
        ready   = 1'b1;
        repeat (4) tick();
        ready   = 1'b0;
        req_tgl = ~req_tgl;
        data_in = 32'h5A5A5A5A;
        repeat (3) tick();
        chk("mid_valid", {31'd0, valid}, 32'd1);
        chk("mid_ack", {31'd0, ack_tgl}, 32'd1);
        #2;
        rst_n   = 1'b0;
        req_tgl = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_ack", {31'd0, ack_tgl}, 32'd0);
        chk("arst_dout", dout, 32'd0);
        chk("arst_timeout", {31'd0, timeout}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", {31'd0, valid}, 32'd0);
        req_tgl = 1'b1;
        data_in = 32'hCAFEF00D;
        ready   = 1'b1;
        tick();
        tick();
        chk("post_rst_early", {31'd0, valid}, 32'd0);
        tick();
        chk("post_rst_cap", {31'd0, valid}, 32'd1);
        chk("post_rst_dout", dout, 32'hCAFEF00D);
        tick();
        chk("post_rst_ack", {31'd0, ack_tgl}, 32'd1);
        chk("post_rst_done", {31'd0, valid}, 32'd0);

`ifdef SYNC_HS_RX_TIMEOUT_EN
        // Expiry with ready low
        ready   = 1'b0;
        req_tgl = 1'b0;
        data_in = 32'h0BADC0DE;
        repeat (3) tick();
        chk("to_valid", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_wait_valid", {31'd0, valid}, 32'd1);
            chk("to_wait_pulse", {31'd0, timeout}, 32'd0);
        end
        tick();
        chk("to_drop", {31'd0, valid}, 32'd0);
        chk("to_pulse", {31'd0, timeout}, 32'd1);
        chk("to_ack", {31'd0, ack_tgl}, 32'd0);
        tick();
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);

        // Accept on the expiry cycle wins
        req_tgl = 1'b1;
        data_in = 32'h600DF00D;
        repeat (3) tick();
        chk("tr_valid", {31'd0, valid}, 32'd1);
        repeat (7) tick();
        chk("tr_c8_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("tr_valid_off", {31'd0, valid}, 32'd0);
        chk("tr_no_pulse", {31'd0, timeout}, 32'd0);
        chk("tr_ack", {31'd0, ack_tgl}, 32'd1);
`else
        // No expiry: valid waits indefinitely
        ready   = 1'b0;
        req_tgl = 1'b0;
        data_in = 32'h0BADC0DE;
        repeat (3) tick();
        for (int i = 0; i < 30; i++) begin
            chk("nto_valid", {31'd0, valid}, 32'd1);
            chk("nto_timeout", {31'd0, timeout}, 32'd0);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("nto_ack", {31'd0, ack_tgl}, 32'd0);
        chk("nto_done", {31'd0, valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
